// File: rtl/lsu_stage_pkg.sv
// Shared constants, state encoding and decode helpers for the load/store stage.
package lsu_stage_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned BE_W  = XLEN / 8;
    localparam int unsigned CNT_W = 8;

    localparam logic [6:0] OP_L = 7'b0000011;
    localparam logic [6:0] OP_S = 7'b0100011;
    localparam logic [6:0] OP_B = 7'b1100011;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_WB     = 2'd2
    } state_e;

    // Operation captured at acceptance and held until retirement.
    typedef struct packed {
        logic [6:0]      opcode;
        logic [2:0]      func3;
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] rs2;
        logic [4:0]      rd;
    } lsu_op_t;

    // True when a load/store has a legal func3 and a naturally aligned address.
    function automatic logic mem_op_ok(input logic [6:0] op,
                                       input logic [2:0] f3,
                                       input logic [1:0] off);
        logic legal;
        logic aligned;
        legal   = 1'b0;
        aligned = 1'b1;
        case (f3)
            F3_B, F3_H, F3_W: legal = 1'b1;
            F3_BU, F3_HU:     legal = (op == OP_L);
            default:          legal = 1'b0;
        endcase
        case (f3)
            F3_H, F3_HU: aligned = ~off[0];
            F3_W:        aligned = (off == 2'b00);
            default:     aligned = 1'b1;
        endcase
        return legal && aligned;
    endfunction

endpackage

// File: rtl/lsu_stage_if.sv
// Data-memory request/acknowledge bus between the load/store stage and memory.
interface lsu_stage_if;
    import lsu_stage_pkg::*;

    logic            dm_req;
    logic [XLEN-1:0] dm_addr;
    logic [BE_W-1:0] dm_we;
    logic [XLEN-1:0] dm_wdata;
    logic            dm_ack;
    logic [XLEN-1:0] dm_rdata;

    // Requester side (the load/store stage).
    modport master (
        output dm_req,
        output dm_addr,
        output dm_we,
        output dm_wdata,
        input  dm_ack,
        input  dm_rdata
    );

    // Responder side (data memory).
    modport slave (
        input  dm_req,
        input  dm_addr,
        input  dm_we,
        input  dm_wdata,
        output dm_ack,
        output dm_rdata
    );

endinterface

// File: rtl/lsu_align.sv
// Combinational store lane placement / byte enables and load extract / extend.
module lsu_align
    import lsu_stage_pkg::*;
(
    input  logic [2:0]      i_func3,
    input  logic [1:0]      i_off,
    input  logic [XLEN-1:0] i_rs2,
    input  logic [XLEN-1:0] i_rdata,
    output logic [BE_W-1:0] o_be_c,
    output logic [XLEN-1:0] o_wdata_c,
    output logic [XLEN-1:0] o_load_c
);

    logic [XLEN-1:0] w_shifted;

    assign w_shifted = i_rdata >> {i_off, 3'b000};

    // Store: replicate the source across lanes and enable only the addressed bytes.
    always_comb begin
        o_be_c    = '0;
        o_wdata_c = '0;
        case (i_func3)
            F3_B: begin
                o_be_c    = 4'b0001 << i_off;
                o_wdata_c = {4{i_rs2[7:0]}};
            end
            F3_H: begin
                o_be_c    = 4'b0011 << i_off;
                o_wdata_c = {2{i_rs2[15:0]}};
            end
            F3_W: begin
                o_be_c    = 4'b1111;
                o_wdata_c = i_rs2;
            end
            default: begin
                o_be_c    = '0;
                o_wdata_c = '0;
            end
        endcase
    end

    // Load: bring the addressed bytes to bit 0, then sign- or zero-extend.
    always_comb begin
        o_load_c = '0;
        case (i_func3)
            F3_B:    o_load_c = {{24{w_shifted[7]}}, w_shifted[7:0]};
            F3_H:    o_load_c = {{16{w_shifted[15]}}, w_shifted[15:0]};
            F3_W:    o_load_c = i_rdata;
            F3_BU:   o_load_c = {24'd0, w_shifted[7:0]};
            F3_HU:   o_load_c = {16'd0, w_shifted[15:0]};
            default: o_load_c = '0;
        endcase
    end

endmodule

// File: rtl/lsu_stage.sv
// RV32I memory-access stage: runs loads/stores over a req/ack bus, passes other results through.
module lsu_stage
    import lsu_stage_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
)(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ex_valid,
    output logic             ex_ready,
    input  logic [6:0]       opcode,
    input  logic [2:0]       func3,
    input  logic [XLEN-1:0]  alu_out,
    input  logic [XLEN-1:0]  rs2_data,
    input  logic [4:0]       rd,
    lsu_stage_if.master      dm,
    output logic             wb_valid,
    output logic             wb_we,
    output logic [4:0]       wb_rd,
    output logic [XLEN-1:0]  wb_data,
    output logic             lsu_err
);

    localparam logic [CNT_W-1:0] TO_CNT = CNT_W'(TIMEOUT);

    state_e          r_state, w_state_next;
    logic [CNT_W-1:0] r_cnt, w_cnt_next, w_cnt_inc;
    lsu_op_t         r_op, w_op_next;
    logic            r_ex_ready, w_ex_ready_next;
    logic            r_dm_req, w_dm_req_next;
    logic [BE_W-1:0] r_dm_we, w_dm_we_next;
    logic [XLEN-1:0] r_dm_wdata, w_dm_wdata_next;
    logic            r_wb_valid, w_wb_valid_next;
    logic            r_wb_we, w_wb_we_next;
    logic [4:0]      r_wb_rd, w_wb_rd_next;
    logic [XLEN-1:0] r_wb_data, w_wb_data_next;
    logic            r_lsu_err, w_lsu_err_next;

    logic            w_is_mem;
    logic            w_mem_ok;
    logic            w_idle;
    logic [2:0]      w_al_func3;
    logic [1:0]      w_al_off;
    logic [XLEN-1:0] w_al_rs2;
    logic [BE_W-1:0] w_al_be;
    logic [XLEN-1:0] w_al_wdata;
    logic [XLEN-1:0] w_al_load;

    assign w_idle    = (r_state == ST_IDLE);
    assign w_is_mem  = (opcode == OP_L) || (opcode == OP_S);
    assign w_mem_ok  = mem_op_ok(opcode, func3, alu_out[1:0]);
    assign w_cnt_inc = r_cnt + CNT_W'(1);

    // Aligner sees the incoming op while idle (store lanes) and the held op afterwards (load extract).
    assign w_al_func3 = w_idle ? func3        : r_op.func3;
    assign w_al_off   = w_idle ? alu_out[1:0] : r_op.addr[1:0];
    assign w_al_rs2   = w_idle ? rs2_data     : r_op.rs2;

    lsu_align u_align (
        .i_func3   (w_al_func3),
        .i_off     (w_al_off),
        .i_rs2     (w_al_rs2),
        .i_rdata   (dm.dm_rdata),
        .o_be_c    (w_al_be),
        .o_wdata_c (w_al_wdata),
        .o_load_c  (w_al_load)
    );

    // State, counter, held op and all output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_op       <= '0;
            r_ex_ready <= 1'b1;
            r_dm_req   <= 1'b0;
            r_dm_we    <= '0;
            r_dm_wdata <= '0;
            r_wb_valid <= 1'b0;
            r_wb_we    <= 1'b0;
            r_wb_rd    <= '0;
            r_wb_data  <= '0;
            r_lsu_err  <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_cnt      <= w_cnt_next;
            r_op       <= w_op_next;
            r_ex_ready <= w_ex_ready_next;
            r_dm_req   <= w_dm_req_next;
            r_dm_we    <= w_dm_we_next;
            r_dm_wdata <= w_dm_wdata_next;
            r_wb_valid <= w_wb_valid_next;
            r_wb_we    <= w_wb_we_next;
            r_wb_rd    <= w_wb_rd_next;
            r_wb_data  <= w_wb_data_next;
            r_lsu_err  <= w_lsu_err_next;
        end
    end

    // Next-state and next-output decode.
    always_comb begin
        w_state_next    = r_state;
        w_cnt_next      = r_cnt;
        w_op_next       = r_op;
        w_dm_req_next   = 1'b0;
        w_dm_we_next    = r_dm_we;
        w_dm_wdata_next = r_dm_wdata;
        w_wb_valid_next = 1'b0;
        w_wb_we_next    = 1'b0;
        w_wb_rd_next    = r_wb_rd;
        w_wb_data_next  = r_wb_data;
        w_lsu_err_next  = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (ex_valid) begin
                    w_op_next = '{opcode: opcode, func3: func3, addr: alu_out,
                                  rs2: rs2_data, rd: rd};
                    w_wb_rd_next = rd;
                    if (w_is_mem && w_mem_ok) begin
                        w_state_next    = ST_ACCESS;
                        w_cnt_next      = '0;
                        w_dm_req_next   = 1'b1;
                        w_dm_we_next    = (opcode == OP_S) ? w_al_be : '0;
                        w_dm_wdata_next = (opcode == OP_S) ? w_al_wdata : '0;
                    end else if (w_is_mem) begin
                        // Misaligned or illegal width: retire with error, never touch memory.
                        w_state_next    = ST_WB;
                        w_wb_valid_next = 1'b1;
                        w_wb_data_next  = '0;
                        w_lsu_err_next  = 1'b1;
                    end else begin
                        w_state_next    = ST_WB;
                        w_wb_valid_next = 1'b1;
                        w_wb_we_next    = (opcode != OP_B) && (rd != 5'd0);
                        w_wb_data_next  = alu_out;
                    end
                end
            end

            ST_ACCESS: begin
                if (dm.dm_ack) begin
                    // Ack takes priority over a coincident timeout.
                    w_state_next    = ST_WB;
                    w_cnt_next      = '0;
                    w_wb_valid_next = 1'b1;
                    if (r_op.opcode == OP_L) begin
                        w_wb_we_next   = (r_op.rd != 5'd0);
                        w_wb_data_next = w_al_load;
                    end else begin
                        w_wb_data_next = '0;
                    end
                end else if (w_cnt_inc == TO_CNT) begin
                    w_state_next    = ST_WB;
                    w_cnt_next      = '0;
                    w_wb_valid_next = 1'b1;
                    w_wb_data_next  = '0;
                    w_lsu_err_next  = 1'b1;
                end else begin
                    w_dm_req_next = 1'b1;
                    w_cnt_next    = w_cnt_inc;
                end
            end

            ST_WB: begin
                w_state_next = ST_IDLE;
            end

            default: begin
                w_state_next = ST_IDLE;
            end
        endcase

        w_ex_ready_next = (w_state_next == ST_IDLE);
    end

    assign ex_ready    = r_ex_ready;
    assign dm.dm_req   = r_dm_req;
    assign dm.dm_addr  = {r_op.addr[XLEN-1:2], 2'b00};
    assign dm.dm_we    = r_dm_we;
    assign dm.dm_wdata = r_dm_wdata;
    assign wb_valid    = r_wb_valid;
    assign wb_we       = r_wb_we;
    assign wb_rd       = r_wb_rd;
    assign wb_data     = r_wb_data;
    assign lsu_err     = r_lsu_err;

endmodule

// File: tb/tb_lsu_stage.sv
// Directed bench for lsu_stage with a retirement scoreboard.
`timescale 1ns/1ps
module tb_lsu_stage;

    localparam int unsigned TO = 4;

    localparam logic [6:0] T_OP_L = 7'b0000011;
    localparam logic [6:0] T_OP_S = 7'b0100011;
    localparam logic [6:0] T_OP_B = 7'b1100011;
    localparam logic [6:0] T_OP_R = 7'b0110011;

    typedef struct {
        logic        we;
        logic [4:0]  rd;
        logic [31:0] data;
        logic        err;
        logic        chk_data;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        ex_valid;
    logic        ex_ready;
    logic [6:0]  opcode;
    logic [2:0]  func3;
    logic [31:0] alu_out;
    logic [31:0] rs2_data;
    logic [4:0]  rd;
    logic        wb_valid;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        lsu_err;

    int n_checks = 0;
    int n_errors = 0;
    exp_t sb[$];

    lsu_stage_if dm_bus();

    lsu_stage #(.TIMEOUT(TO)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ex_valid (ex_valid),
        .ex_ready (ex_ready),
        .opcode   (opcode),
        .func3    (func3),
        .alu_out  (alu_out),
        .rs2_data (rs2_data),
        .rd       (rd),
        .dm       (dm_bus),
        .wb_valid (wb_valid),
        .wb_we    (wb_we),
        .wb_rd    (wb_rd),
        .wb_data  (wb_data),
        .lsu_err  (lsu_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic mem_legal(input logic [6:0] opc, input logic [2:0] f3,
                                       input logic [1:0] off);
        logic size_ok;
        if (opc == T_OP_L) size_ok = f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        else               size_ok = f3 inside {3'b000, 3'b001, 3'b010};
        if (!size_ok) return 1'b0;
        if (f3[1:0] == 2'b01) return (off[0] == 1'b0);
        if (f3[1:0] == 2'b10) return (off == 2'b00);
        return 1'b1;
    endfunction

    function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [1:0] off);
        logic [3:0] be;
        int size;
        size = 1 << f3[1:0];
        for (int i = 0; i < 4; i++) be[i] = (i >= int'(off)) && (i < int'(off) + size);
        return be;
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] v);
        case (f3[1:0])
            2'b00:   return {v[7:0], v[7:0], v[7:0], v[7:0]};
            2'b01:   return {v[15:0], v[15:0]};
            default: return v;
        endcase
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [1:0] off,
                                               input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        case (off)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            default: b = w[31:24];
        endcase
        h = off[1] ? w[31:16] : w[15:0];
        case (f3)
            3'b000:  return {{24{b[7]}}, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b100:  return {24'd0, b};
            3'b101:  return {16'd0, h};
            default: return w;
        endcase
    endfunction

    // Issue one op, play memory (ack after ack_after cycles, <0 = never) and check timing.
    task automatic issue(input logic [6:0] opc, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] rs2, input logic [4:0] rdi,
                         input int ack_after, input logic [31:0] rdata);
        exp_t e;
        logic is_load, is_mem, ok;
        int   guard, cyc, exp_cyc;
        is_load = (opc == T_OP_L);
        is_mem  = is_load || (opc == T_OP_S);
        ok      = is_mem && mem_legal(opc, f3, addr[1:0]);
        guard = 0;
        while (!ex_ready && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        chk("ex_ready_before_issue", 32'(ex_ready), 32'd1);

        if (!is_mem)
            e = '{we: (opc != T_OP_B) && (rdi != 5'd0), rd: rdi, data: addr, err: 1'b0, chk_data: 1'b1};
        else if (!ok)
            e = '{we: 1'b0, rd: rdi, data: 32'd0, err: 1'b1, chk_data: 1'b0};
        else if (ack_after < 0 || ack_after >= int'(TO))
            e = '{we: 1'b0, rd: rdi, data: 32'd0, err: 1'b1, chk_data: 1'b0};
        else if (is_load)
            e = '{we: (rdi != 5'd0), rd: rdi, data: model_load(f3, addr[1:0], rdata), err: 1'b0, chk_data: 1'b1};
        else
            e = '{we: 1'b0, rd: rdi, data: 32'd0, err: 1'b0, chk_data: 1'b1};
        sb.push_back(e);

        ex_valid = 1'b1; opcode = opc; func3 = f3; alu_out = addr; rs2_data = rs2; rd = rdi;
        @(posedge clk); #1;
        ex_valid = 1'b0;
        alu_out  = 32'hDEAD_0000;
        rs2_data = 32'hDEAD_0001;

        if (ok) begin
            exp_cyc = (ack_after >= 0 && ack_after < int'(TO)) ? ack_after + 1 : int'(TO);
            chk("dm_req_first_access_cycle", 32'(dm_bus.dm_req), 32'd1);
            cyc = 0;
            while (dm_bus.dm_req && cyc < 300) begin
                chk("ex_ready_in_access", 32'(ex_ready), 32'd0);
                chk("dm_addr", dm_bus.dm_addr, {addr[31:2], 2'b00});
                chk("dm_we", 32'(dm_bus.dm_we), is_load ? 32'd0 : 32'(model_be(f3, addr[1:0])));
                if (!is_load) chk("dm_wdata", dm_bus.dm_wdata, model_wdata(f3, rs2));
                if (cyc == ack_after) begin
                    dm_bus.dm_ack   = 1'b1;
                    dm_bus.dm_rdata = rdata;
                end
                @(posedge clk); #1;
                dm_bus.dm_ack   = 1'b0;
                dm_bus.dm_rdata = 32'h5A5A_A5A5;
                cyc++;
            end
            chk("dm_req_cycles", 32'(cyc), 32'(exp_cyc));
        end else begin
            chk("no_dm_req", 32'(dm_bus.dm_req), 32'd0);
        end
        chk("wb_valid_pulse", 32'(wb_valid), 32'd1);
        chk("ex_ready_in_wb", 32'(ex_ready), 32'd0);
        @(posedge clk); #1;
        chk("wb_valid_drop", 32'(wb_valid), 32'd0);
        chk("ex_ready_after_wb", 32'(ex_ready), 32'd1);
    endtask

    // Scoreboard: every retirement must match the oldest pending expectation.
    always @(negedge clk) begin
        if (wb_valid) begin
            exp_t e;
            n_checks++;
            assert (sb.size() != 0) else begin
                n_errors++;
                $error("FAIL wb_unexpected: observed wb_valid=1 rd=%0d expected no retirement", wb_rd);
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("wb_we", 32'(wb_we), 32'(e.we));
                chk("wb_rd", 32'(wb_rd), 32'(e.rd));
                chk("lsu_err", 32'(lsu_err), 32'(e.err));
                if (e.chk_data) chk("wb_data", wb_data, e.data);
            end
        end else if (rst_n) begin
            chk("lsu_err_without_wb", 32'(lsu_err), 32'd0);
        end
    end

    initial begin
        rst_n = 1'b0; ex_valid = 1'b0; opcode = '0; func3 = '0;
        alu_out = '0; rs2_data = '0; rd = '0;
        dm_bus.dm_ack = 1'b0; dm_bus.dm_rdata = '0;
        #12;
        chk("rst_ex_ready", 32'(ex_ready), 32'd1);
        chk("rst_dm_req", 32'(dm_bus.dm_req), 32'd0);
        chk("rst_dm_we", 32'(dm_bus.dm_we), 32'd0);
        chk("rst_dm_addr", dm_bus.dm_addr, 32'd0);
        chk("rst_wb_valid", 32'(wb_valid), 32'd0);
        chk("rst_wb_data", wb_data, 32'd0);
        chk("rst_lsu_err", 32'(lsu_err), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // LB sign-extend from top byte, ack after 2 cycles.
        issue(T_OP_L, 3'b000, 32'h0000_1003, 32'd0, 5'd3, 2, 32'h8000_0000);
        // SH upper half, immediate ack.
        issue(T_OP_S, 3'b001, 32'h0000_2002, 32'h0000_ABCD, 5'd0, 0, 32'd0);
        // Misaligned LW.
        issue(T_OP_L, 3'b010, 32'h0000_1001, 32'd0, 5'd4, 0, 32'd0);
        // SW with no ack: timeout.
        issue(T_OP_S, 3'b010, 32'h0000_3000, 32'hCAFE_F00D, 5'd0, -1, 32'd0);
        // ALU result then LBU to x0, back to back.
        issue(T_OP_R, 3'b000, 32'h1234_5678, 32'd0, 5'd5, 0, 32'd0);
        issue(T_OP_L, 3'b100, 32'h0000_4000, 32'd0, 5'd0, 1, 32'h0000_00FF);
        // Halfword sign/zero extend, byte store lane, word load.
        issue(T_OP_L, 3'b001, 32'h0000_4002, 32'd0, 5'd6, 0, 32'h8001_1234);
        issue(T_OP_L, 3'b101, 32'h0000_4002, 32'd0, 5'd7, 1, 32'h8001_1234);
        issue(T_OP_S, 3'b000, 32'h0000_5001, 32'h1111_225A, 5'd0, 0, 32'd0);
        issue(T_OP_L, 3'b010, 32'h0000_6000, 32'd0, 5'd8, 0, 32'hDEAD_BEEF);
        issue(T_OP_L, 3'b000, 32'h0000_6002, 32'd0, 5'd9, 0, 32'h0070_0000);
        // Illegal store width, misaligned SH, branch result.
        issue(T_OP_S, 3'b011, 32'h0000_7000, 32'd0, 5'd0, 0, 32'd0);
        issue(T_OP_S, 3'b001, 32'h0000_7003, 32'd0, 5'd0, 0, 32'd0);
        issue(T_OP_B, 3'b000, 32'h0000_0ABC, 32'd0, 5'd7, 0, 32'd0);
        // Ack in the same cycle the counter would expire.
        issue(T_OP_L, 3'b010, 32'h0000_8000, 32'd0, 5'd10, int'(TO) - 1, 32'h0BAD_CAFE);

        // Reset during ACCESS loses the op.
        @(posedge clk); #1;
        ex_valid = 1'b1; opcode = T_OP_L; func3 = 3'b010; alu_out = 32'h0000_9000; rd = 5'd11;
        @(posedge clk); #1;
        ex_valid = 1'b0;
        chk("rst_test_dm_req_up", 32'(dm_bus.dm_req), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_dm_req", 32'(dm_bus.dm_req), 32'd0);
        chk("async_rst_ex_ready", 32'(ex_ready), 32'd1);
        chk("async_rst_wb_valid", 32'(wb_valid), 32'd0);
        @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            chk("post_rst_ex_ready", 32'(ex_ready), 32'd1);
            chk("post_rst_dm_req", 32'(dm_bus.dm_req), 32'd0);
            chk("post_rst_wb_valid", 32'(wb_valid), 32'd0);
        end

        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
